// File: rtl/score_pkg.sv
// Shared definitions for the score-to-BCD converter: default sizes and the
// conversion FSM state encoding.
package score_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_add3_cell (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Add-3 correction, purely combinational
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Serial binary-to-BCD converter for the game score display. Watches score_in,
// and whenever it differs from the last converted value runs a WIDTH-cycle
// double-dabble conversion, then publishes the BCD digits together with a
// leading-zero blanking mask for the seven-segment scan mux.
module score_bcd_converter
  import score_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic [WIDTH-1:0]      score_in,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  busy,
  output logic                  done
);

  localparam int ACC_W = DIGITS * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t            state;
  logic [WIDTH-1:0]  last_bin;
  logic [WIDTH-1:0]  shift_reg;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_adj;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DIGITS-1:0] blank_nxt;

  // One add-3 cell per digit; the whole accumulator is corrected every cycle
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .digit_in  (acc[g*4 +: 4]),
      .digit_out (acc_adj[g*4 +: 4])
    );
  end

  // Leading-zero mask from the finished accumulator: a digit is blanked when it
  // and every digit above it are zero; the ones digit always shows.
  always_comb begin
    logic zero_above;
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (acc[i*4 +: 4] == 4'd0);
      blank_nxt[i] = zero_above;
    end
  end

  // Conversion FSM with registered outputs
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      state     <= ST_IDLE;
      last_bin  <= '0;
      shift_reg <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      bcd_out   <= '0;
      blank_out <= BLANK_RST;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Changes that arrived while busy are picked up here, so the
          // latest score is always converted eventually.
          if (score_in != last_bin) begin
            last_bin  <= score_in;
            shift_reg <= score_in;
            acc       <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Corrected accumulator and shift register move left as one word
          acc       <= (acc_adj << 1) | {{(ACC_W-1){1'b0}}, shift_reg[WIDTH-1]};
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Digits and mask change together, only here
          bcd_out   <= acc;
          blank_out <= blank_nxt;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: directed scenarios with literal expectations
// plus randomized score changes, all checked every cycle against a decimal
// reference model.
module tb_score_bcd_converter;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                ClkPort = 1'b0;
  logic                Reset   = 1'b1;
  logic [WIDTH-1:0]    score_in = '0;
  logic [DIGITS*4-1:0] bcd_out;
  logic [DIGITS-1:0]   blank_out;
  logic                busy;
  logic                done;

  score_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .ClkPort   (ClkPort),
    .Reset     (Reset),
    .score_in  (score_in),
    .bcd_out   (bcd_out),
    .blank_out (blank_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 ClkPort = ~ClkPort;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v, ones digit lowest
  function automatic logic [DIGITS*4-1:0] ref_bcd(input int v);
    logic [DIGITS*4-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i is blank when the value has fewer than i+1 decimal digits
  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  // Reference model: a conversion starts when an idle converter sees a new
  // score, and publishes the decimal value WIDTH+1 edges later.
  logic [WIDTH-1:0]    m_last = '0;
  logic [WIDTH-1:0]    m_val  = '0;
  int                  m_edge = 0;
  bit                  m_active = 1'b0;
  logic [DIGITS*4-1:0] m_bcd = '0;
  logic [DIGITS-1:0]   m_blank = '0;
  bit                  m_done = 1'b0;
  bit                  chk_en = 1'b0;

  always @(posedge ClkPort) begin
    if (Reset) begin
      m_last   = '0;
      m_active = 1'b0;
      m_edge   = 0;
      m_bcd    = '0;
      m_blank  = ref_blank(0);
      m_done   = 1'b0;
      chk_en   = 1'b1;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (score_in != m_last) begin
          m_last   = score_in;
          m_val    = score_in;
          m_active = 1'b1;
          m_edge   = 0;
        end
      end else begin
        m_edge++;
        if (m_edge == WIDTH + 1) begin
          m_bcd    = ref_bcd(int'(m_val));
          m_blank  = ref_blank(int'(m_val));
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge ClkPort) begin
    if (chk_en) begin
      chk("bcd_out",   32'(bcd_out),   32'(m_bcd));
      chk("blank_out", 32'(blank_out), 32'(m_blank));
      chk("busy",      32'(busy),      32'(m_active));
      chk("done",      32'(done),      32'(m_done));
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge ClkPort);
      if (done === 1'b1) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int snap;

    // Reset and idle with score 0: nothing happens for 40 cycles
    Reset = 1'b1;
    repeat (2) @(negedge ClkPort);
    Reset = 1'b0;
    repeat (40) @(negedge ClkPort);
    chk("rst_bcd",   32'(bcd_out),   32'h00000);
    chk("rst_blank", 32'(blank_out), 32'b11110);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_nodone", 32'(done_cnt), 32'd0);

    // 2048: busy across the conversion, done after edge 17
    score_in = 16'd2048;
    @(negedge ClkPort);
    chk("b2048_busy_e0", 32'(busy), 32'd1);
    repeat (16) @(negedge ClkPort);
    chk("b2048_busy_e16", 32'(busy), 32'd1);
    chk("b2048_nodone_e16", 32'(done), 32'd0);
    @(negedge ClkPort);
    chk("b2048_done_e17", 32'(done), 32'd1);
    chk("b2048_bcd",   32'(bcd_out),   32'h02048);
    chk("b2048_blank", 32'(blank_out), 32'b10000);
    repeat (3) @(negedge ClkPort);

    // Maximum input
    score_in = 16'hFFFF;
    wait_done("max_done");
    chk("max_bcd",   32'(bcd_out),   32'h65535);
    chk("max_blank", 32'(blank_out), 32'b00000);
    repeat (3) @(negedge ClkPort);

    // Change during conversion is deferred, not lost
    score_in = 16'd4;
    repeat (5) @(negedge ClkPort);
    score_in = 16'd8;
    wait_done("defer_done1");
    chk("defer_bcd1", 32'(bcd_out), 32'h00004);
    @(negedge ClkPort);
    chk("defer_restart_busy", 32'(busy), 32'd1);
    wait_done("defer_done2");
    chk("defer_bcd2", 32'(bcd_out), 32'h00008);
    repeat (3) @(negedge ClkPort);

    // Reset mid-conversion aborts it
    snap = done_cnt;
    score_in = 16'd1024;
    repeat (8) @(negedge ClkPort);
    Reset = 1'b1;
    @(negedge ClkPort);
    Reset = 1'b0;
    chk("abort_nodone", 32'(done_cnt), 32'(snap));
    chk("abort_bcd",   32'(bcd_out),   32'h00000);
    chk("abort_blank", 32'(blank_out), 32'b11110);
    chk("abort_busy",  32'(busy),      32'd0);
    wait_done("abort_redo_done");
    chk("abort_redo_bcd", 32'(bcd_out), 32'h01024);
    repeat (3) @(negedge ClkPort);

    // Blank mask across a digit boundary
    score_in = 16'd9;
    wait_done("nine_done");
    chk("nine_bcd",   32'(bcd_out),   32'h00009);
    chk("nine_blank", 32'(blank_out), 32'b11110);
    @(negedge ClkPort);
    score_in = 16'd10;
    wait_done("ten_done");
    chk("ten_bcd",   32'(bcd_out),   32'h00010);
    chk("ten_blank", 32'(blank_out), 32'b11100);

    // Randomized score changes with occasional resets
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        Reset = 1'b1;
        @(negedge ClkPort);
        Reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0)
        score_in = WIDTH'($urandom_range(0, 99));
      else
        score_in = WIDTH'($urandom_range(0, 65535));
      repeat ($urandom_range(1, 40)) @(negedge ClkPort);
    end
    repeat (45) @(negedge ClkPort);
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
